// File: rtl/mux_nx1_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_nx1_pkg
// Purpose  : Shared constants and cyclic priority search for mux_nx1_pipe.
// Revision : 1.0 - initial release
// ============================================================================
package mux_nx1_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Holding-register states; FULL is the single-entry name for ONE.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    // Index of the first set bit of req at or after ptr, wrapping at n.
    // Scanning downward lets the closest candidate overwrite farther ones.
    function automatic int rr_first(input logic [31:0] req, input int ptr, input int n);
        int idx;
        int j;
        idx = 0;
        for (int k = 31; k >= 0; k--) begin
            if (k < n) begin
                j = ptr + k;
                if (j >= n) j = j - n;
                if (req[j]) idx = j;
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_nx1_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_nx1_pipe_if
// Purpose  : Producer/consumer bundle of the N:1 pipelined mux.
// Revision : 1.0 - initial release
// ============================================================================
interface mux_nx1_pipe_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SW = $clog2(N);

    logic           mode;
    logic [SW-1:0]  sel;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/mux_nx1_pipe_arb.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Grant for the N:1 mux, explicit select or round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mux_nx1_pkg::*;
#(
    parameter int N = 4,
    localparam int SW = $clog2(N)
) (
    input  wire logic [N-1:0]  i_req,
    input  wire logic [SW-1:0] i_ptr,
    input  wire logic          i_mode,
    input  wire logic [SW-1:0] i_sel,
    output logic [N-1:0]       o_grant,
    output logic [SW-1:0]      o_grant_idx,
    output logic               o_grant_vld
);
    int            w_rr_idx;
    logic [SW-1:0] w_idx;
    logic          w_vld;

    always_comb begin
        w_rr_idx = rr_first(32'(i_req), int'(i_ptr), N);
        w_idx    = '0;
        w_vld    = 1'b0;
        if (i_mode == MODE_RR) begin
            w_vld = |i_req;
            w_idx = SW'(w_rr_idx);
        end else if ((int'(i_sel) < N) && i_req[i_sel]) begin
            w_vld = 1'b1;
            w_idx = i_sel;
        end
        o_grant = '0;
        if (w_vld) o_grant[w_idx] = 1'b1;
        o_grant_idx = w_idx;
        o_grant_vld = w_vld;
    end
endmodule
`default_nettype wire

// File: rtl/mux_nx1_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mux_nx1_pipe
// Purpose  : N-input registered mux with valid/ready and select/RR modes.
//            MUX_NX1_PIPE_SKID_EN adds a second entry, cutting out_ready->in_ready.
// Revision : 1.0 - initial release
// ============================================================================
module mux_nx1_pipe
    import mux_nx1_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mux_nx1_pipe_if.slave bus
);
    localparam int SW = $clog2(N);

    logic [1:0]    r_state;
    logic [W-1:0]  r_data0;
`ifdef MUX_NX1_PIPE_SKID_EN
    logic [W-1:0]  r_data1;
`endif
    logic [SW-1:0] r_ptr;

    logic [N-1:0]  w_grant;
    logic [SW-1:0] w_grant_idx;
    logic          w_grant_vld;
    logic          w_space;
    logic          w_push;
    logic          w_pop;
    logic [W-1:0]  w_in_word;

    rr_arbiter #(.N(N)) u_arb (
        .i_req       (bus.in_valid),
        .i_ptr       (r_ptr),
        .i_mode      (bus.mode),
        .i_sel       (bus.sel),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_grant_vld (w_grant_vld)
    );

`ifdef MUX_NX1_PIPE_SKID_EN
    assign w_space = (r_state != ST_TWO);
`else
    assign w_space = (r_state == ST_EMPTY) || bus.out_ready;
`endif

    assign w_push    = w_grant_vld && w_space && !rst;
    assign w_pop     = (r_state != ST_EMPTY) && bus.out_ready;
    assign w_in_word = bus.in_data[w_grant_idx*W +: W];

    assign bus.in_ready  = w_grant & {N{w_space && !rst}};
    assign bus.out_valid = (r_state != ST_EMPTY);
    assign bus.out_data  = r_data0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_data0 <= '0;
`ifdef MUX_NX1_PIPE_SKID_EN
            r_data1 <= '0;
`endif
            r_ptr   <= '0;
        end else begin
            if (w_push && (bus.mode == MODE_RR))
                r_ptr <= (w_grant_idx == SW'(N - 1)) ? '0 : w_grant_idx + 1'b1;
`ifdef MUX_NX1_PIPE_SKID_EN
            // r_data0 is always the head word so out_data stays FIFO-ordered.
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        r_data0 <= w_in_word;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        r_data0 <= w_in_word;
                    end else if (w_push) begin
                        r_data1 <= w_in_word;
                        r_state <= ST_TWO;
                    end else if (w_pop) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        r_data0 <= r_data1;
                        r_state <= ST_ONE;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
`else
            if (w_push) begin
                r_data0 <= w_in_word;
                r_state <= ST_FULL;
            end else if (w_pop) begin
                r_state <= ST_EMPTY;
            end
`endif
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mux_nx1_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_nx1_pipe
// Purpose  : Self-checking bench for mux_nx1_pipe against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_nx1_pipe;
    import mux_nx1_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = $clog2(N);
    localparam int N5 = 5;
    localparam int D5 = N5 * W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_nx1_pipe_if #(.N(N),  .W(W)) bus ();
    mux_nx1_pipe_if #(.N(N5), .W(W)) bus5 ();

    mux_nx1_pipe #(.N(N),  .W(W)) dut  (.clk(clk), .rst(rst), .bus(bus));
    mux_nx1_pipe #(.N(N5), .W(W)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_hold;
    int           m_ptr;
    logic         m5_vld;
    logic [N-1:0] last_acc;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Channel the rules select this cycle, -1 if none.
    function automatic int m_grant();
        int j;
        if (bus.mode == MODE_RR) begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (bus.in_valid[j]) return j;
            end
            return -1;
        end
        if (int'(bus.sel) < N && bus.in_valid[bus.sel]) return int'(bus.sel);
        return -1;
    endfunction

    // Check outputs for the current inputs, then advance model across one edge.
    task automatic step();
        int            g;
        logic          space;
        logic [N-1:0]  exp_rdy;
        logic [N5-1:0] exp5;
        logic [W-1:0]  exp_data;
        #1;
        g = m_grant();
`ifdef MUX_NX1_PIPE_SKID_EN
        space = (m_q.size() < 2);
`else
        space = (m_q.size() == 0) || bus.out_ready;
`endif
        exp_rdy = '0;
        if (g >= 0 && space && !rst) exp_rdy[g] = 1'b1;
        exp_data = (m_q.size() > 0) ? m_q[0] : m_hold;
        chk("in_ready",  64'(bus.in_ready),  64'(exp_rdy));
        chk("out_valid", 64'(bus.out_valid), 64'(m_q.size() > 0));
        chk("out_data",  64'(bus.out_data),  64'(exp_data));
        exp5 = '0;
        if (!rst && int'(bus5.sel) < N5 && bus5.in_valid[bus5.sel]) exp5[bus5.sel] = 1'b1;
        chk("n5_in_ready",  64'(bus5.in_ready),  64'(exp5));
        chk("n5_out_valid", 64'(bus5.out_valid), 64'(m5_vld));
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_ptr  = 0;
            m_hold = '0;
            m5_vld = 1'b0;
        end else begin
            if (m_q.size() > 0 && bus.out_ready) m_hold = m_q.pop_front();
            if (exp_rdy != '0) begin
                m_q.push_back(bus.in_data[g*W +: W]);
                if (bus.mode == MODE_RR) m_ptr = (g + 1) % N;
            end
            m5_vld = (exp5 != '0) || (m5_vld && !bus5.out_ready);
        end
        last_acc = exp_rdy;
        @(negedge clk);
    endtask

    initial begin
        m_hold   = '0;
        m_ptr    = 0;
        m5_vld   = 1'b0;
        last_acc = '0;
        rst           = 1'b1;
        bus.mode      = MODE_SEL;
        bus.sel       = '0;
        bus.in_valid  = '1;
        bus.in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.out_ready = 1'b1;
        bus5.mode      = MODE_SEL;
        bus5.sel       = 3'd5;
        bus5.in_valid  = '1;
        bus5.in_data   = D5'(40'h5544332211);
        bus5.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // Reset held with every channel valid
        repeat (2) step();
        rst = 1'b0;
        step();

        // Explicit select, then round-robin over all four channels
        bus.sel = 2'd2;
        repeat (3) step();
        bus5.sel = 3'd6;
        bus.mode = MODE_RR;
        repeat (9) step();
        bus.in_valid = 4'b1001;
        repeat (4) step();

        // Backpressure with a held word
        bus.mode     = MODE_SEL;
        bus.sel      = 2'd1;
        bus.in_valid = '1;
        step();
        bus.out_ready = 1'b0;
        repeat (3) step();
        bus.sel       = 2'd3;
        bus.out_ready = 1'b1;
        repeat (2) step();

        // Mid-stream reset, then RR restarts from channel 0
        bus.mode = MODE_RR;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) step();

        // Randomized traffic; producers hold words until accepted
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.in_valid[i] || last_acc[i]) begin
                    bus.in_valid[i]          = ($urandom_range(0, 3) != 0);
                    bus.in_data[i*W +: W]    = W'($urandom);
                end
            end
            if ($urandom_range(0, 7) == 0) bus.mode = ~bus.mode;
            bus.sel       = SW'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            rst           = ($urandom_range(0, 60) == 0);
            bus5.sel      = 3'($urandom);
            bus5.in_valid = N5'($urandom);
            bus5.in_data  = D5'({$urandom, $urandom});
            step();
        end
        rst = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
